dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder_if.sv | 36 +++
 rtl/dm_responder.sv | 136 +++++++++++++
 tb/tb_dm_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder_if
// Description : CPU <-> data-memory request/response bundle for dm_responder.
//               master : CPU side, drives the request fields and observes the
//                        response flags and read data.
//               slave  : responder side, the mirror image.
//               Request : DM_enable, DM_read, DM_write, DM_address, DM_in
//               Response: DM_out, DM_ready, DM_busy, DM_error
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  DM_enable;
    logic                  DM_read;
    logic                  DM_write;
    logic [ADDR_WIDTH-1:0] DM_address;
    logic [DATA_WIDTH-1:0] DM_in;
    logic [DATA_WIDTH-1:0] DM_out;
    logic                  DM_ready;
    logic                  DM_busy;
    logic                  DM_error;

    modport master (
        output DM_enable, DM_read, DM_write, DM_address, DM_in,
        input  DM_out, DM_ready, DM_busy, DM_error
    );

    modport slave (
        input  DM_enable, DM_read, DM_write, DM_address, DM_in,
        output DM_out, DM_ready, DM_busy, DM_error
    );
endinterface
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_responder
// Description : Single-port data memory with a three-state access FSM
//               (IDLE -> WAIT -> RESP -> IDLE) and a programmable number of
//               wait states before each response.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous, active-low reset
//               bus  - dm_responder_if.slave (request in, response out)
// Parameters  : ADDR_WIDTH  - word address width (2**ADDR_WIDTH words)
//               DATA_WIDTH  - word width
//               WAIT_CYCLES - wait states per access, 0..15
// Revision    : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dm_responder_if.slave  bus
);

    localparam int         c_DEPTH     = 1 << ADDR_WIDTH;
    localparam bit         c_NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] c_WAIT_LOAD = c_NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_idle;
    logic                  w_legal_req;
    logic                  w_illegal_req;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_acc_write;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_data;

    assign w_idle        = (r_state == c_IDLE);
    assign w_legal_req   = bus.DM_enable & (bus.DM_read ^ bus.DM_write);
    assign w_illegal_req = bus.DM_enable & bus.DM_read & bus.DM_write;
    assign w_accept      = w_idle & w_legal_req;

    // With zero wait states the RESP-entry edge is the acceptance edge itself,
    // so the access has to be served from the live request fields; otherwise
    // it is served from the copy latched at acceptance.
    assign w_enter_resp = (w_accept & c_NO_WAIT) |
                          ((r_state == c_WAIT) & (r_cnt == 4'd0));
    assign w_acc_write  = w_idle ? bus.DM_write   : r_is_write;
    assign w_acc_addr   = w_idle ? bus.DM_address : r_addr;
    assign w_acc_data   = w_idle ? bus.DM_in      : r_wdata;

    // Access sequencing
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_error <= 1'b0;
        end else begin
            // Error is only reported for a conflicting request seen in IDLE;
            // anything arriving while busy is dropped without comment.
            r_error <= w_idle & w_illegal_req;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (c_NO_WAIT) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Request capture; these only matter while an access is in flight, so
    // they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_write <= bus.DM_write;
            r_addr     <= bus.DM_address;
            r_wdata    <= bus.DM_in;
        end
    end

    // Storage array. Reset does not clear it, but a reset on the commit edge
    // cancels the pending write.
    always_ff @(posedge clk) begin
        if (rst && w_enter_resp && w_acc_write) begin
            r_mem[w_acc_addr] <= w_acc_data;
        end
    end

    // Read data holds the last completed read; writes never touch it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out <= '0;
        end else if (w_enter_resp && !w_acc_write) begin
            r_out <= r_mem[w_acc_addr];
        end
    end

    assign bus.DM_out   = r_out;
    assign bus.DM_ready = (r_state == c_RESP);
    assign bus.DM_busy  = (r_state != c_IDLE);
    assign bus.DM_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_responder
// Description : Self-checking bench for dm_responder. Three instances with
//               WAIT_CYCLES = 0, 3 and 2 receive the same accesses; a
//               reference model predicts each response into a per-instance
//               queue, and a monitor pops and compares on every DM_ready.
//               Busy and error flags are compared every cycle against the
//               windows the model computes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

    localparam int NK   = 3;
    localparam int MAXW = 3;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_v   [NK];
    logic        rd_v   [NK];
    logic        wr_v   [NK];
    logic [11:0] addr_v [NK];
    logic [31:0] din_v  [NK];
    logic [31:0] out_v  [NK];
    logic        ready_v[NK];
    logic        busy_v [NK];
    logic        error_v[NK];

    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_on      = 1'b0;

    exp_t        sb       [NK][$];
    int          busy_lo  [NK];
    int          busy_hi  [NK];
    int          err_cyc  [NK];
    logic [31:0] out_val  [NK];
    bit          out_known[NK];
    logic [31:0] ref_mem  [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        dm_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
        assign bus.DM_enable  = en_v[g];
        assign bus.DM_read    = rd_v[g];
        assign bus.DM_write   = wr_v[g];
        assign bus.DM_address = addr_v[g];
        assign bus.DM_in      = din_v[g];
        assign out_v[g]       = bus.DM_out;
        assign ready_v[g]     = bus.DM_ready;
        assign busy_v[g]      = bus.DM_busy;
        assign error_v[g]     = bus.DM_error;
        dm_responder #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (32),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    function automatic int wv(int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic exp_t mk(int c, logic [31:0] d, bit ck);
        exp_t e;
        e.cyc = c; e.data = d; e.chk = ck;
        return e;
    endfunction

    function automatic void check(string name, int k, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s w=%0d cyc=%0d got=%h expected=%h", name, wv(k), cyc, got, want);
        end
    endfunction

    // Monitor: flags every cycle, data/timing on each DM_ready
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_on) begin
            for (int k = 0; k < NK; k++) begin
                check("busy", k, 32'(busy_v[k]), 32'(cyc > busy_lo[k] && cyc <= busy_hi[k]));
                check("error", k, 32'(error_v[k]), 32'(cyc == err_cyc[k]));
                if (ready_v[k] === 1'b1) begin
                    if (sb[k].size() == 0) begin
                        check("unexpected_ready", k, 32'd1, 32'd0);
                    end else begin
                        e = sb[k].pop_front();
                        check("ready_cycle", k, 32'(cyc), 32'(e.cyc));
                        if (e.chk) check("dm_out", k, out_v[k], e.data);
                    end
                end
            end
        end
    end

    task automatic idle_all();
        for (int k = 0; k < NK; k++) begin
            en_v[k] = 1'b0; rd_v[k] = 1'b0; wr_v[k] = 1'b0;
            addr_v[k] = 12'h0; din_v[k] = 32'h0;
        end
    endtask

    task automatic post_reset_checks();
        for (int k = 0; k < NK; k++) begin
            check("rst_out", k, out_v[k], 32'h0);
            check("rst_ready", k, 32'(ready_v[k]), 32'h0);
            check("rst_busy", k, 32'(busy_v[k]), 32'h0);
        end
    endtask

    // Called just after a falling edge; the request is sampled on the next
    // rising edge (E0). rst_at > 0 pulls reset low on edge E0+rst_at.
    // noise drives random request fields while each instance is busy.
    task automatic access(bit wr, logic [11:0] addr, logic [31:0] data,
                          int rst_at, bit noise);
        int e0;
        int key;
        bit done;
        e0 = cyc;
        for (int k = 0; k < NK; k++) begin
            en_v[k] = 1'b1; rd_v[k] = !wr; wr_v[k] = wr;
            addr_v[k] = addr; din_v[k] = data;
            done       = (rst_at <= 0) || (rst_at > wv(k));
            busy_lo[k] = e0;
            busy_hi[k] = done ? e0 + wv(k) + 1 : e0 + rst_at;
            key        = k * 4096 + int'(addr);
            if (done) begin
                if (wr) begin
                    sb[k].push_back(mk(e0 + wv(k) + 1, out_val[k], out_known[k]));
                    ref_mem[key] = data;
                end else if (ref_mem.exists(key)) begin
                    sb[k].push_back(mk(e0 + wv(k) + 1, ref_mem[key], 1'b1));
                    out_val[k] = ref_mem[key]; out_known[k] = 1'b1;
                end else begin
                    sb[k].push_back(mk(e0 + wv(k) + 1, 32'h0, 1'b0));
                    out_known[k] = 1'b0;
                end
            end
            if (rst_at > 0) begin
                out_val[k] = 32'h0; out_known[k] = 1'b1;
            end
        end
        for (int n = 1; n <= MAXW + 1; n++) begin
            @(negedge clk);
            rst = (rst_at != n);
            if (rst_at > 0 && n == rst_at + 1) post_reset_checks();
            for (int k = 0; k < NK; k++) begin
                if (noise && n <= wv(k) + 1 && (rst_at <= 0 || n <= rst_at)) begin
                    en_v[k] = 1'($urandom); rd_v[k] = 1'($urandom); wr_v[k] = 1'($urandom);
                    addr_v[k] = 12'($urandom); din_v[k] = $urandom;
                end else begin
                    en_v[k] = 1'b0; rd_v[k] = 1'b0; wr_v[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        if (rst_at == MAXW + 1) post_reset_checks();
        idle_all();
    endtask

    task automatic illegal(logic [11:0] addr, logic [31:0] data);
        for (int k = 0; k < NK; k++) begin
            en_v[k] = 1'b1; rd_v[k] = 1'b1; wr_v[k] = 1'b1;
            addr_v[k] = addr; din_v[k] = data;
            err_cyc[k] = cyc + 1;
        end
        @(negedge clk);
        idle_all();
        @(negedge clk);
    endtask

    task automatic write(logic [11:0] a, logic [31:0] d);
        access(1'b1, a, d, 0, 1'b0);
    endtask

    task automatic read(logic [11:0] a);
        access(1'b0, a, 32'h0, 0, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [11:0] pool [7];
        logic [11:0] a;
        int r;
        pool = '{12'h000, 12'h001, 12'h002, 12'h004, 12'h010, 12'hFFE, 12'hFFF};
        for (int k = 0; k < NK; k++) begin
            busy_lo[k] = -1; busy_hi[k] = -1; err_cyc[k] = -1;
            out_val[k] = 32'h0; out_known[k] = 1'b1;
        end
        idle_all();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            check("reset_out", k, out_v[k], 32'h0);
            check("reset_ready", k, 32'(ready_v[k]), 32'h0);
            check("reset_busy", k, 32'(busy_v[k]), 32'h0);
            check("reset_error", k, 32'(error_v[k]), 32'h0);
        end
        rst    = 1'b1;
        mon_on = 1'b1;

        // Basic write then read back
        write(12'h004, 32'hDEADBEEF);
        read(12'h004);
        // Preloaded word read with wait states
        write(12'h010, 32'h12345678);
        read(12'h010);
        // Conflicting request must not write
        write(12'h020, 32'h0000AAAA);
        illegal(12'h020, 32'hFFFFFFFF);
        read(12'h020);
        // Reset in WAIT and on the RESP-entry edge discards the write
        write(12'hFFF, 32'h11111111);
        access(1'b1, 12'hFFF, 32'h55AA55AA, 1, 1'b0);
        read(12'hFFF);
        access(1'b1, 12'hFFF, 32'h55AA55AA, 2, 1'b0);
        read(12'hFFF);
        // Request fields changing during WAIT are ignored
        write(12'h000, 32'hC0DE0000);
        write(12'h001, 32'hC0DE0001);
        access(1'b0, 12'h000, 32'h0, 0, 1'b1);
        read(12'h001);
        // Extremes of the address range do not alias
        write(12'h000, 32'h0000000A);
        write(12'hFFF, 32'h0000000B);
        read(12'h000);
        read(12'hFFF);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : pool[$urandom_range(0, 6)];
            if (r == 0) begin
                illegal(a, $urandom);
            end else begin
                access(r < 5, a, $urandom,
                       (r == 9) ? int'($urandom_range(1, MAXW + 1)) : 0,
                       1'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            check("pending_responses", k, 32'(sb[k].size()), 32'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
